// File: rtl/branch_pred_pkg.sv
// rtl/branch_pred_pkg.sv - shared types and counter policy for the branch predictor
// Purpose: 2-bit counter states, BTB entry kinds and the saturating counter update.
// Ports: none (package).
package branch_pred_pkg;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  typedef enum logic [1:0] {
    K_BR   = 2'd0,
    K_JAL  = 2'd1,
    K_JALR = 2'd2
  } kind_t;

  // Step the counter toward taken/not-taken, holding at ST and SNT.
  function automatic ctr_t sat_update(input ctr_t c, input logic taken);
    ctr_t n;
    n = c;
    case (c)
      SNT: n = taken ? WNT : SNT;
      WNT: n = taken ? WT  : SNT;
      WT:  n = taken ? ST  : WNT;
      ST:  n = taken ? ST  : WT;
      default: n = WNT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/bp_btb_table.sv
// rtl/bp_btb_table.sv - direct-mapped BTB storage array
// Purpose: holds valid/tag/kind/target/ctr per entry.
// Ports:
//   clk, reset         clock and async active-low reset
//   rd_idx -> rd_*     combinational read for the IF lookup
//   chk_idx -> chk_*   combinational read of the entry being resolved in EX
//   wr_en, wr_idx, wr_* registered write of a full entry
import branch_pred_pkg::*;

module bp_btb_table #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 3,
  parameter int PC_W  = 9,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output kind_t            rd_kind,
  output logic [PC_W-1:0]  rd_target,
  output ctr_t             rd_ctr,
  input  logic [IDX_W-1:0] chk_idx,
  output logic             chk_valid,
  output logic [TAG_W-1:0] chk_tag,
  output kind_t            chk_kind,
  output logic [PC_W-1:0]  chk_target,
  output ctr_t             chk_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [TAG_W-1:0] wr_tag,
  input  kind_t            wr_kind,
  input  logic [PC_W-1:0]  wr_target,
  input  ctr_t             wr_ctr
);

  logic             valid_q  [DEPTH];
  logic [TAG_W-1:0] tag_q    [DEPTH];
  kind_t            kind_q   [DEPTH];
  logic [PC_W-1:0]  target_q [DEPTH];
  ctr_t             ctr_q    [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        kind_q[i]   <= K_BR;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else if (wr_en) begin
      valid_q[wr_idx]  <= wr_valid;
      tag_q[wr_idx]    <= wr_tag;
      kind_q[wr_idx]   <= wr_kind;
      target_q[wr_idx] <= wr_target;
      ctr_q[wr_idx]    <= wr_ctr;
    end
  end

  // Reads see registered contents only: a same-cycle write is not bypassed.
  assign rd_valid   = valid_q[rd_idx];
  assign rd_tag     = tag_q[rd_idx];
  assign rd_kind    = kind_q[rd_idx];
  assign rd_target  = target_q[rd_idx];
  assign rd_ctr     = ctr_q[rd_idx];

  assign chk_valid  = valid_q[chk_idx];
  assign chk_tag    = tag_q[chk_idx];
  assign chk_kind   = kind_q[chk_idx];
  assign chk_target = target_q[chk_idx];
  assign chk_ctr    = ctr_q[chk_idx];

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - EX branch resolver with BTB prediction in IF
// Purpose: predicts taken/target for the fetch PC, resolves branches/jumps in EX,
//          flags mispredicts with a redirect PC, trains the BTB, counts mispredicts.
// Ports:
//   clk, reset                 clock and async active-low reset
//   if_valid, if_pc            IF lookup request -> pred_taken, pred_target
//   ex_*                       EX instruction and the prediction piped from IF
//   pc_imm, pc_four            ex_pc+imm, ex_pc+4 (32-bit wrap)
//   act_taken, act_target      resolved outcome
//   mispredict, redirect_pc    redirect request to PC mux / flush
//   mispredict_cnt             saturating mispredict count
import branch_pred_pkg::*;

module branch_predict_unit #(
  parameter int PC_W      = 9,
  parameter int BTB_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_valid,
  input  logic [PC_W-1:0]  if_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic [PC_W-1:0]  ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic             ex_branch,
  input  logic             ex_jmp_sel,
  input  logic [1:0]       ex_aluop,
  input  logic [31:0]      ex_alu_result,
  input  logic             ex_pred_taken,
  input  logic [PC_W-1:0]  ex_pred_target,
  output logic [31:0]      pc_imm,
  output logic [31:0]      pc_four,
  output logic             act_taken,
  output logic [31:0]      act_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = PC_W - IDX_W - 2;

  generate
    if (PC_W <= IDX_W + 2) begin : g_bad_pc_w
      $error("branch_predict_unit: PC_W must exceed IDX_W+2");
    end
    if (BTB_DEPTH < 2 || BTB_DEPTH > 256 || (1 << IDX_W) != BTB_DEPTH) begin : g_bad_depth
      $error("branch_predict_unit: BTB_DEPTH must be a power of two in 2..256");
    end
  endgenerate

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[PC_W-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[PC_W-1:IDX_W+2];

  logic             rd_valid, chk_valid;
  logic [TAG_W-1:0] rd_tag, chk_tag;
  kind_t            rd_kind, chk_kind;
  logic [PC_W-1:0]  rd_target, chk_target;
  ctr_t             rd_ctr, chk_ctr;

  logic             wr_en, wr_valid;
  kind_t            wr_kind;
  logic [PC_W-1:0]  wr_target;
  ctr_t             wr_ctr;

  bp_btb_table #(
    .DEPTH (BTB_DEPTH),
    .TAG_W (TAG_W),
    .PC_W  (PC_W)
  ) u_table (
    .clk        (clk),
    .reset      (reset),
    .rd_idx     (if_idx),
    .rd_valid   (rd_valid),
    .rd_tag     (rd_tag),
    .rd_kind    (rd_kind),
    .rd_target  (rd_target),
    .rd_ctr     (rd_ctr),
    .chk_idx    (ex_idx),
    .chk_valid  (chk_valid),
    .chk_tag    (chk_tag),
    .chk_kind   (chk_kind),
    .chk_target (chk_target),
    .chk_ctr    (chk_ctr),
    .wr_en      (wr_en),
    .wr_idx     (ex_idx),
    .wr_valid   (wr_valid),
    .wr_tag     (ex_tag),
    .wr_kind    (wr_kind),
    .wr_target  (wr_target),
    .wr_ctr     (wr_ctr)
  );

  // IF lookup: jumps are always predicted taken; branches follow ctr[1].
  logic if_hit;
  assign if_hit      = if_valid & rd_valid & (rd_tag == if_tag);
  assign pred_taken  = if_hit & ((rd_kind != K_BR) | rd_ctr[1]);
  assign pred_target = if_hit ? rd_target : '0;

  // EX resolution
  logic [31:0] ex_pc_ext;
  logic        is_jalr;
  assign ex_pc_ext  = {{(32-PC_W){1'b0}}, ex_pc};
  assign pc_imm     = ex_pc_ext + ex_imm;
  assign pc_four    = ex_pc_ext + 32'd4;
  assign is_jalr    = ex_jmp_sel & (ex_aluop == 2'b00);
  assign act_taken  = ex_valid & ((ex_branch & ex_alu_result[0]) | ex_jmp_sel);
  assign act_target = is_jalr ? ex_alu_result : pc_imm;

  assign mispredict  = ex_valid & ((act_taken != ex_pred_taken) |
                       (act_taken & ex_pred_taken & (act_target[PC_W-1:0] != ex_pred_target)));
  assign redirect_pc = act_taken ? act_target : pc_four;

  // Training. A valid non-control instruction that was predicted taken means
  // the IF lookup aliased onto this PC; drop the entry if it is ours.
  logic ex_hit, is_ctrl, alias_clear;
  assign ex_hit      = chk_valid & (chk_tag == ex_tag);
  assign is_ctrl     = ex_branch | ex_jmp_sel;
  assign alias_clear = ex_valid & ~is_ctrl & ex_pred_taken & ex_hit;

  always_comb begin
    wr_en     = 1'b0;
    wr_valid  = 1'b0;
    wr_kind   = chk_kind;
    wr_target = chk_target;
    wr_ctr    = chk_ctr;
    if (ex_valid & is_ctrl) begin
      wr_en     = 1'b1;
      wr_valid  = 1'b1;
      wr_kind   = ex_jmp_sel ? (is_jalr ? K_JALR : K_JAL) : K_BR;
      wr_target = act_target[PC_W-1:0];
      if (ex_jmp_sel)
        wr_ctr = ST;
      else if (ex_hit)
        wr_ctr = sat_update(chk_ctr, act_taken);
      else
        wr_ctr = act_taken ? WT : WNT;
    end else if (alias_clear) begin
      wr_en    = 1'b1;
      wr_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      mispredict_cnt <= '0;
    else if (mispredict && (mispredict_cnt != {CNT_W{1'b1}}))
      mispredict_cnt <= mispredict_cnt + 1'b1;
  end

  // Low PC bits are always zero for word-aligned fetch.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = &{1'b0, if_pc[1:0], ex_pc[1:0]};

endmodule
